// File: rtl/video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_timing_gen                                                         |
// | Raster position counter with registered sync/blank/frame decode and      |
// | enable-gated delayed copies of sync and draw-enable.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module video_timing_gen #(
   parameter int   H_ACTIVE   = 1280,
   parameter int   H_FP       = 110,
   parameter int   H_SYNC     = 40,
   parameter int   H_BP       = 220,
   parameter int   V_ACTIVE   = 720,
   parameter int   V_FP       = 5,
   parameter int   V_SYNC     = 5,
   parameter int   V_BP       = 20,
   parameter logic SYNC_POL   = 1'b1,
   parameter int   PIPE_DELAY = 4,
   parameter int   FC_WIDTH   = 6
) (
   input  logic                pixel_clk_in,
   input  logic                rst_in,
   input  logic                pixel_en_in,
   output logic [10:0]         hcount_out,
   output logic [9:0]          vcount_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                active_draw_out,
   output logic                new_frame_out,
   output logic [FC_WIDTH-1:0] frame_count_out,
   output logic                hsync_d_out,
   output logic                vsync_d_out,
   output logic                active_draw_d_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // One extra bit so a boundary equal to the full count width still compares correctly
   localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] C_H_ACTIVE = 12'(H_ACTIVE);
   localparam logic [11:0] C_HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
   localparam logic [10:0] C_V_NF     = 11'(V_ACTIVE - 1);
   localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 2048) begin : g_bad_htotal
      $error("video_timing_gen: H_TOTAL exceeds 2048");
   end
   if (V_TOTAL > 1024) begin : g_bad_vtotal
      $error("video_timing_gen: V_TOTAL exceeds 1024");
   end

   logic [10:0]         h_q, h_d, h_nxt;
   logic [9:0]          v_q, v_d, v_nxt;
   logic [10:0]         hcount_q, hcount_d;
   logic [9:0]          vcount_q, vcount_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                active_q, active_d;
   logic                new_frame_q, new_frame_d;
   logic [FC_WIDTH-1:0] frame_count_q, frame_count_d;
   logic                h_wrap;
   logic [11:0]         h_ext;
   logic [10:0]         v_ext;

   always_comb begin
      h_wrap        = ({1'b0, h_q} == C_H_LAST);
      h_nxt         = h_wrap ? 11'd0 : h_q + 11'd1;
      v_nxt         = v_q;
      if (h_wrap) begin
         v_nxt = ({1'b0, v_q} == C_V_LAST) ? 10'd0 : v_q + 10'd1;
      end
      h_ext         = {1'b0, h_nxt};
      v_ext         = {1'b0, v_nxt};

      h_d           = h_q;
      v_d           = v_q;
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      active_d      = active_q;
      new_frame_d   = 1'b0;
      frame_count_d = frame_count_q;

      if (pixel_en_in) begin
         h_d         = h_nxt;
         v_d         = v_nxt;
         hcount_d    = h_nxt;
         vcount_d    = v_nxt;
         hsync_d     = (h_ext >= C_HS_START && h_ext < C_HS_END) ? SYNC_POL : ~SYNC_POL;
         vsync_d     = (v_ext >= C_VS_START && v_ext < C_VS_END) ? SYNC_POL : ~SYNC_POL;
         active_d    = (h_ext < C_H_ACTIVE) && (v_ext < C_V_ACTIVE);
         new_frame_d = (h_ext == C_H_ACTIVE) && (v_ext == C_V_NF);
         if (new_frame_d) begin
            frame_count_d = frame_count_q + FC_WIDTH'(1);
         end
      end
   end

   // Position parks on the last pixel so the first enabled edge emits (0,0)
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         h_q           <= C_H_LAST[10:0];
         v_q           <= C_V_LAST[9:0];
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         active_q      <= 1'b0;
         new_frame_q   <= 1'b0;
         frame_count_q <= '0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         new_frame_q   <= new_frame_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign hcount_out      = hcount_q;
   assign vcount_out      = vcount_q;
   assign hsync_out       = hsync_q;
   assign vsync_out       = vsync_q;
   assign active_draw_out = active_q;
   assign new_frame_out   = new_frame_q;
   assign frame_count_out = frame_count_q;

   if (PIPE_DELAY > 0) begin : g_pipe
      logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
      logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
      logic [PIPE_DELAY-1:0] ad_pipe_q, ad_pipe_d;

      // Stage 0 captures the registered outputs, giving exactly PIPE_DELAY of lag
      always_comb begin
         hs_pipe_d = hs_pipe_q;
         vs_pipe_d = vs_pipe_q;
         ad_pipe_d = ad_pipe_q;
         if (pixel_en_in) begin
            hs_pipe_d = PIPE_DELAY'({hs_pipe_q, hsync_q});
            vs_pipe_d = PIPE_DELAY'({vs_pipe_q, vsync_q});
            ad_pipe_d = PIPE_DELAY'({ad_pipe_q, active_q});
         end
      end

      always_ff @(posedge pixel_clk_in or posedge rst_in) begin
         if (rst_in) begin
            hs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
            vs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
            ad_pipe_q <= '0;
         end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            ad_pipe_q <= ad_pipe_d;
         end
      end

      assign hsync_d_out       = hs_pipe_q[PIPE_DELAY-1];
      assign vsync_d_out       = vs_pipe_q[PIPE_DELAY-1];
      assign active_draw_d_out = ad_pipe_q[PIPE_DELAY-1];
   end else begin : g_nopipe
      assign hsync_d_out       = hsync_q;
      assign vsync_d_out       = vsync_q;
      assign active_draw_d_out = active_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_video_timing_gen                                                      |
// | Directed bench: small 14x7 raster, delay 4 / delay 0 / 2-bit frame count.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_video_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;

   always #5 clk = ~clk;

   // a_*: PIPE_DELAY=4, FC_WIDTH=6; z_*: PIPE_DELAY=0; w_*: FC_WIDTH=2
   logic [10:0] a_h, z_h, w_h;
   logic [9:0]  a_v, z_v, w_v;
   logic        a_hs, a_vs, a_act, a_nf, a_hsd, a_vsd, a_actd;
   logic        z_hs, z_vs, z_act, z_nf, z_hsd, z_vsd, z_actd;
   logic        w_hs, w_vs, w_act, w_nf, w_hsd, w_vsd, w_actd;
   logic [5:0]  a_fc, z_fc;
   logic [1:0]  w_fc;

   video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1),
      .PIPE_DELAY(4), .FC_WIDTH(6)) dut_a (
      .pixel_clk_in(clk), .rst_in(rst), .pixel_en_in(en),
      .hcount_out(a_h), .vcount_out(a_v), .hsync_out(a_hs), .vsync_out(a_vs),
      .active_draw_out(a_act), .new_frame_out(a_nf), .frame_count_out(a_fc),
      .hsync_d_out(a_hsd), .vsync_d_out(a_vsd), .active_draw_d_out(a_actd));

   video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1),
      .PIPE_DELAY(0), .FC_WIDTH(6)) dut_z (
      .pixel_clk_in(clk), .rst_in(rst), .pixel_en_in(en),
      .hcount_out(z_h), .vcount_out(z_v), .hsync_out(z_hs), .vsync_out(z_vs),
      .active_draw_out(z_act), .new_frame_out(z_nf), .frame_count_out(z_fc),
      .hsync_d_out(z_hsd), .vsync_d_out(z_vsd), .active_draw_d_out(z_actd));

   video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1),
      .PIPE_DELAY(4), .FC_WIDTH(2)) dut_w (
      .pixel_clk_in(clk), .rst_in(rst), .pixel_en_in(en),
      .hcount_out(w_h), .vcount_out(w_v), .hsync_out(w_hs), .vsync_out(w_vs),
      .active_draw_out(w_act), .new_frame_out(w_nf), .frame_count_out(w_fc),
      .hsync_d_out(w_hsd), .vsync_d_out(w_vsd), .active_draw_d_out(w_actd));

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: internal position plus expected registered outputs
   int   ph, pv, eh, ev, efc, n, nf_count, pidx;
   logic ehs, evs, eact, enf;
   logic hs_hist [0:1023];
   logic vs_hist [0:1023];
   logic ad_hist [0:1023];
   logic [1:0] fc2_seq [0:3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph = 13; pv = 6; eh = 0; ev = 0; efc = 0; n = 0;
      ehs = 1'b0; evs = 1'b0; eact = 1'b0; enf = 1'b0;
      hs_hist[0] = 1'b0; vs_hist[0] = 1'b0; ad_hist[0] = 1'b0;
   endtask

   task automatic model_step();
      if (ph == 13) begin
         ph = 0;
         pv = (pv == 6) ? 0 : pv + 1;
      end else begin
         ph = ph + 1;
      end
      eh   = ph;
      ev   = pv;
      ehs  = (ph == 10 || ph == 11);
      evs  = (pv == 5);
      eact = (ph < 8 && pv < 4);
      enf  = (ph == 8 && pv == 3);
      if (enf) efc = efc + 1;
      n = n + 1;
      hs_hist[n] = ehs; vs_hist[n] = evs; ad_hist[n] = eact;
   endtask

   task automatic check_all();
      logic dhs, dvs, dad;
      dhs = (n >= 4) ? hs_hist[n-4] : 1'b0;
      dvs = (n >= 4) ? vs_hist[n-4] : 1'b0;
      dad = (n >= 4) ? ad_hist[n-4] : 1'b0;
      check("hcount", a_h, eh);
      check("vcount", a_v, ev);
      check("hsync", a_hs, ehs);
      check("vsync", a_vs, evs);
      check("active_draw", a_act, eact);
      check("new_frame", a_nf, enf);
      check("frame_count", a_fc, efc % 64);
      check("hsync_d4", a_hsd, dhs);
      check("vsync_d4", a_vsd, dvs);
      check("active_draw_d4", a_actd, dad);
      check("hsync_d0", z_hsd, ehs);
      check("vsync_d0", z_vsd, evs);
      check("active_draw_d0", z_actd, eact);
      check("fc2_frame_count", w_fc, efc % 4);
      check("fc2_new_frame", w_nf, enf);
   endtask

   task automatic tick();
      if (rst) model_reset();
      else if (en) model_step();
      else enf = 1'b0;
      @(posedge clk);
      #1;
      if (a_nf === 1'b1) nf_count++;
      check_all();
      if (!rst && en && enf && pidx < 4) begin
         check("fc2_sequence", w_fc, fc2_seq[pidx]);
         check("fc6_sequence", a_fc, pidx + 1);
         pidx++;
      end
   endtask

   initial begin
      int guard;
      nf_count = 0;
      pidx = 0;
      fc2_seq[0] = 2'd1; fc2_seq[1] = 2'd2; fc2_seq[2] = 2'd3; fc2_seq[3] = 2'd0;
      model_reset();

      // Held in reset with enable high
      repeat (3) tick();

      // Release: first enabled edge emits (0,0)
      rst = 1'b0;
      tick();
      check("release_hcount", a_h, 0);
      check("release_vcount", a_v, 0);
      check("release_active", a_act, 1);

      // active_draw rose at enabled step 1, delayed copy rises at step 5
      repeat (3) tick();
      check("align_before_rise", a_actd, 0);
      tick();
      check("align_rise", a_actd, 1);

      // Line wrap: (13,0) followed by (0,1)
      while (n < 14) tick();
      check("line_end_h", a_h, 13);
      check("line_end_hsync", a_hs, 0);
      tick();
      check("line_wrap_h", a_h, 0);
      check("line_wrap_v", a_v, 1);

      // Run to the first frame marker, then stall there
      guard = 0;
      while (!(eh == 8 && ev == 3) && guard < 200) begin tick(); guard++; end
      check("reach_first_marker", guard < 200, 1);
      check("marker_pulse", a_nf, 1);
      check("marker_fc", a_fc, 1);
      en = 1'b0;
      repeat (5) tick();
      check("stall_h", a_h, 8);
      check("stall_v", a_v, 3);
      check("stall_no_repulse", a_nf, 0);
      en = 1'b1;
      tick();
      check("resume_h", a_h, 9);
      check("resume_v", a_v, 3);
      check("resume_fc", a_fc, 1);

      // Complete four frames in total, walking the 2-bit counter through its wrap
      guard = 0;
      while (efc < 4 && guard < 500) begin tick(); guard++; end
      check("reach_fourth_marker", guard < 500, 1);
      check("pulse_count", nf_count, 4);
      check("fc2_wrapped", w_fc, 0);
      check("fc6_four", a_fc, 4);

      // Mid-frame asynchronous reset at (5,2)
      guard = 0;
      while (!(eh == 5 && ev == 2) && guard < 200) begin tick(); guard++; end
      check("reach_reset_point", guard < 200, 1);
      check("pre_reset_active", a_act, 1);
      rst = 1'b1;
      #1;
      check("async_hcount", a_h, 0);
      check("async_vcount", a_v, 0);
      check("async_active", a_act, 0);
      check("async_fc", a_fc, 0);
      check("async_hsync", a_hs, 0);
      check("async_active_d", a_actd, 0);
      check("async_fc2", w_fc, 0);
      tick();
      rst = 1'b0;
      tick();
      check("restart_h", a_h, 0);
      check("restart_v", a_v, 0);
      check("restart_fc", a_fc, 0);
      check("restart_flushed_d", a_actd, 0);
      repeat (6) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator that walks a parameterised video frame pixel by pixel. It drives `hcount`/`vcount` into the sprite/pixel-lookup stages and produces sync, blanking and frame markers. It also provides copies of the sync and draw-enable signals delayed by a fixed pipeline depth, so they arrive at the video encoder aligned with the RGB produced by the downstream BRAM lookup chain. It sits directly upstream of the image sprite stage in the pixel-clock domain.

## Interface
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 110, horizontal front porch (pixels)
- `H_SYNC`, 40, horizontal sync width (pixels)
- `H_BP`, 220, horizontal back porch (pixels); `H_TOTAL = sum of H_*`
- `V_ACTIVE`, 720, visible lines per frame
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vertical sync width (lines)
- `V_BP`, 20, vertical back porch (lines); `V_TOTAL = sum of V_*`
- `SYNC_POL`, 1, asserted level of hsync/vsync
- `PIPE_DELAY`, 4, delay (in enabled cycles) for the `_d` outputs; 0 permitted
- `FC_WIDTH`, 6, frame counter width

Ports:
- `pixel_clk_in` in 1: pixel clock; all logic on rising edge
- `rst_in` in 1: asynchronous, active-high reset
- `pixel_en_in` in 1: advance enable; low freezes all state
- `hcount_out` out 11: current column, 0..H_TOTAL-1
- `vcount_out` out 10: current line, 0..V_TOTAL-1
- `hsync_out` out 1: horizontal sync, level SYNC_POL when asserted
- `vsync_out` out 1: vertical sync, level SYNC_POL when asserted
- `active_draw_out` out 1: high when hcount<H_ACTIVE and vcount<V_ACTIVE
- `new_frame_out` out 1: one-cycle pulse at the first blanking pixel of a frame
- `frame_count_out` out FC_WIDTH: frames completed, wraps modulo 2^FC_WIDTH
- `hsync_d_out`, `vsync_d_out`, `active_draw_d_out` out 1 each: inputs delayed by PIPE_DELAY enabled cycles

## Operation
- Position is tracked internally. Every output is registered: on each enabled edge, the position advances and the outputs take the decode of the new position.
- Advance rule:
  - h increments each enabled cycle.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At (H_TOTAL-1, V_TOTAL-1), both h and v wrap to 0.
- Reset loads the internal position to (H_TOTAL-1, V_TOTAL-1), so the first enabled edge after release emits (0,0).
- `hsync_out` = SYNC_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise !SYNC_POL.
- `vsync_out` = SYNC_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; asserts and deasserts coincident with h=0 of the line.
- `new_frame_out` is high for exactly one enabled cycle, when the emitted position is (H_ACTIVE, V_ACTIVE-1). On that same edge, `frame_count_out` increments.
- `_d` outputs are a PIPE_DELAY-deep shift register that shifts only when `pixel_en_in`=1.
  - Shift-register contents reset to the inactive values: sync = !SYNC_POL, draw = 0.
  - PIPE_DELAY=0 makes each `_d` output equal its undelayed output.
- Widths: counters compare at full width. Parameter sets with H_TOTAL>2048 or V_TOTAL>1024 are illegal; the RTL asserts this in simulation.

## Timing
- Reset values, held while `rst_in`=1 (asynchronous assertion):
  - `hcount_out`=0, `vcount_out`=0, `active_draw_out`=0, `new_frame_out`=0, `frame_count_out`=0
  - all sync outputs = !SYNC_POL
  - `active_draw_d_out`=0
- Latency: hcount/vcount/sync/active_draw/new_frame are valid 1 cycle after the enabled edge that computes them. The `_d` outputs lag their sources by exactly PIPE_DELAY enabled cycles.
- `pixel_en_in`=0: all outputs hold their values. `new_frame_out` drops to 0 after its single cycle and is not re-asserted while stalled.
- Reset mid-frame: immediate return to reset values. Restart is at (0,0) with `frame_count_out`=0 and the `_d` pipeline flushed.
- Wrap of `frame_count_out` from 2^FC_WIDTH-1 to 0 occurs on the `new_frame_out` edge, with no extra pulse.
- Simultaneous line and frame wrap at (H_TOTAL-1, V_TOTAL-1) takes one cycle, with no dead cycle.

## Test plan
All scenarios use the small test parameters H=8/2/2/2 (H_TOTAL=14), V=4/1/1/1 (V_TOTAL=7), PIPE_DELAY=4 unless stated.

- **Reset release:** release `rst_in`, hold `pixel_en_in`=1.
  - Cycle 1 after release: hcount=0, vcount=0, active_draw=1.
  - While still in reset: all outputs at their reset values.
- **Line timing:** run one line.
  - active_draw=1 for h=0..7.
  - hsync=1 for h=10,11 only.
  - After h=13, the next emitted position is h=0, v=1.
- **Frame timing:** run 2 frames (196 cycles).
  - new_frame pulses once per frame, at (8,3).
  - vsync=1 for v=5 only.
  - frame_count reads 1, then 2.
- **Stall:** drop `pixel_en_in` for 5 cycles at (8,3).
  - Outputs frozen, new_frame high for one cycle only.
  - Resume continues from (9,3).
- **Delay alignment:** `active_draw_d_out` rises exactly 4 enabled cycles after `active_draw_out`.
  - Rerun with PIPE_DELAY=0: `_d` outputs equal the undelayed outputs every cycle.
- **Wrap and mid-frame reset:**
  - With FC_WIDTH=2, frame_count sequence is 1,2,3,0.
  - Assert `rst_in` at (5,2): outputs return to reset values immediately, and restart is at (0,0) with frame_count=0.
